// File: rtl/sfx_pkg.sv
// Shared types and default timing for the sound-effect beeper.
// Sound ids are ordered so that a larger encoding means a higher priority.
package sfx_pkg;

    typedef enum logic [1:0] {
        SND_NONE  = 2'd0,
        SND_FLAP  = 2'd1,
        SND_SCORE = 2'd2,
        SND_CRASH = 2'd3
    } sound_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    localparam int unsigned DEF_CLK_HZ     = 50_000_000;
    localparam int unsigned DEF_FLAP_HALF  = 25_000;
    localparam int unsigned DEF_FLAP_LEN   = 5_000_000;
    localparam int unsigned DEF_SCORE_HALF = 12_500;
    localparam int unsigned DEF_SCORE_LEN  = 2_500_000;
    localparam int unsigned DEF_CRASH_HALF = 50_000;
    localparam int unsigned DEF_CRASH_LEN  = 25_000_000;

    function automatic int unsigned maxOf3(input int unsigned a, input int unsigned b,
                                           input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed for a counter running 0..n-1, never less than one.
    function automatic int unsigned widthFor(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sfx_beeper_tone_gen.sv
// Half-period divider producing a square-wave tone bit.
// Exposes the next tone value so the caller can register it without an extra cycle of lag.
module tone_gen #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         restart_i,
    input  logic         run_i,
    input  logic [W-1:0] halfLast_i,
    output logic         toneNext_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tone_q, tone_d;

    // A restart always begins on the high half of the waveform.
    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (restart_i) begin
            cnt_d  = '0;
            tone_d = 1'b1;
        end else if (!run_i) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (cnt_q == halfLast_i) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
        end else begin
            cnt_d  = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign toneNext_o = tone_d;

endmodule

// File: rtl/sfx_beeper.sv
// Prioritised sound-effect player: accepts flap/score/crash events and drives a
// square-wave buzzer plus busy/LED indication for a fixed duration per sound.
module sfx_beeper
    import sfx_pkg::*;
#(
    parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
    parameter int unsigned FLAP_HALF  = DEF_FLAP_HALF,
    parameter int unsigned FLAP_LEN   = DEF_FLAP_LEN,
    parameter int unsigned SCORE_HALF = DEF_SCORE_HALF,
    parameter int unsigned SCORE_LEN  = DEF_SCORE_LEN,
    parameter int unsigned CRASH_HALF = DEF_CRASH_HALF,
    parameter int unsigned CRASH_LEN  = DEF_CRASH_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flap_pulse,
    input  logic score_pulse,
    input  logic crash_pulse,
    input  logic mute,
    output logic buzzer,
    output logic led_n,
    output logic busy
);

    localparam int unsigned HALF_W = widthFor(maxOf3(FLAP_HALF, SCORE_HALF, CRASH_HALF));
    localparam int unsigned LEN_W  = widthFor(maxOf3(FLAP_LEN, SCORE_LEN, CRASH_LEN));

    // CLK_HZ documents the intended clock; no timing is derived from it.
    if (CLK_HZ == 0) begin : g_clkHzUnset
    end

    state_e             state_q;
    sound_e             id_q;
    sound_e             reqId;
    logic [LEN_W-1:0]   dur_q;
    logic               busy_q, ledN_q, buzzer_q;
    logic [HALF_W-1:0]  halfLast;
    logic [LEN_W-1:0]   lenLast;
    logic               accept, expire, playNext, toneNext;

    always_comb begin
        reqId = SND_NONE;
        if (crash_pulse)      reqId = SND_CRASH;
        else if (score_pulse) reqId = SND_SCORE;
        else if (flap_pulse)  reqId = SND_FLAP;
    end

    always_comb begin
        halfLast = '0;
        lenLast  = '0;
        case (id_q)
            SND_FLAP: begin
                halfLast = HALF_W'(FLAP_HALF - 1);
                lenLast  = LEN_W'(FLAP_LEN - 1);
            end
            SND_SCORE: begin
                halfLast = HALF_W'(SCORE_HALF - 1);
                lenLast  = LEN_W'(SCORE_LEN - 1);
            end
            SND_CRASH: begin
                halfLast = HALF_W'(CRASH_HALF - 1);
                lenLast  = LEN_W'(CRASH_LEN - 1);
            end
            default: begin
                halfLast = '0;
                lenLast  = '0;
            end
        endcase
    end

    // id_q is NONE while idle, so the priority test also admits any pulse in IDLE.
    assign accept   = (reqId != SND_NONE) && (reqId >= id_q);
    assign expire   = (state_q == ST_PLAY) && (dur_q == lenLast);
    assign playNext = accept || ((state_q == ST_PLAY) && !expire);

    tone_gen #(.W(HALF_W)) u_tone (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart_i  (accept),
        .run_i      (playNext),
        .halfLast_i (halfLast),
        .toneNext_o (toneNext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            id_q     <= SND_NONE;
            dur_q    <= '0;
            busy_q   <= 1'b0;
            ledN_q   <= 1'b1;
            buzzer_q <= 1'b0;
        end else begin
            buzzer_q <= playNext & toneNext & ~mute;
            if (accept) begin
                state_q <= ST_PLAY;
                id_q    <= reqId;
                dur_q   <= '0;
                busy_q  <= 1'b1;
                ledN_q  <= 1'b0;
            end else if (state_q == ST_PLAY) begin
                if (expire) begin
                    state_q <= ST_IDLE;
                    id_q    <= SND_NONE;
                    dur_q   <= '0;
                    busy_q  <= 1'b0;
                    ledN_q  <= 1'b1;
                end else begin
                    dur_q   <= dur_q + LEN_W'(1);
                end
            end
        end
    end

    assign buzzer = buzzer_q;
    assign led_n  = ledN_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_sfx_beeper.sv
// Directed bench for sfx_beeper: an age-based reference model queues the expected
// outputs for each driven cycle, and they are popped and compared half a clock later.
module tb_sfx_beeper;

    localparam int FH = 4;
    localparam int FL = 32;
    localparam int SH = 2;
    localparam int SL = 16;
    localparam int CH = 8;
    localparam int CL = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic flap, score, crash, mute;
    logic buzzer, led_n, busy;

    sfx_beeper #(
        .CLK_HZ     (50_000_000),
        .FLAP_HALF  (FH),
        .FLAP_LEN   (FL),
        .SCORE_HALF (SH),
        .SCORE_LEN  (SL),
        .CRASH_HALF (CH),
        .CRASH_LEN  (CL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flap_pulse  (flap),
        .score_pulse (score),
        .crash_pulse (crash),
        .mute        (mute),
        .buzzer      (buzzer),
        .led_n       (led_n),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic busy;
        logic ledN;
        logic buzzer;
    } outs_t;

    outs_t sbq[$];

    int totalChecks  = 0;
    int passedChecks = 0;
    int failedChecks = 0;
    int cyc          = 0;
    int busyCount    = 0;

    bit mActive = 1'b0;
    int mId     = 0;
    int mAge    = 0;

    function automatic int halfOf(input int id);
        case (id)
            1:       return FH;
            2:       return SH;
            3:       return CH;
            default: return 1;
        endcase
    endfunction

    function automatic int lenOf(input int id);
        case (id)
            1:       return FL;
            2:       return SL;
            3:       return CL;
            default: return 1;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        totalChecks++;
        assert (obs === exp) passedChecks++;
        else begin
            failedChecks++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkCount(input string tag, input int obs, input int exp);
        totalChecks++;
        assert (obs == exp) passedChecks++;
        else begin
            failedChecks++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs, predicts the post-edge outputs, then checks them.
    task automatic applyStimulus(input bit f, input bit s, input bit c, input bit m);
        int    req;
        outs_t e;
        outs_t got;
        flap  = f;
        score = s;
        crash = c;
        mute  = m;
        req = c ? 3 : (s ? 2 : (f ? 1 : 0));
        if (req != 0 && (!mActive || req >= mId)) begin
            mActive = 1'b1;
            mId     = req;
            mAge    = 0;
        end else if (mActive) begin
            mAge++;
            if (mAge >= lenOf(mId)) begin
                mActive = 1'b0;
                mId     = 0;
                mAge    = 0;
            end
        end
        e.busy   = mActive;
        e.ledN   = !mActive;
        e.buzzer = 1'b0;
        if (mActive)
            e.buzzer = (((mAge / halfOf(mId)) % 2) == 0) && !m;
        sbq.push_back(e);
        @(negedge clk);
        cyc++;
        got = sbq.pop_front();
        checkOutput($sformatf("busy@%0d", cyc), busy, got.busy);
        checkOutput($sformatf("led_n@%0d", cyc), led_n, got.ledN);
        checkOutput($sformatf("buzzer@%0d", cyc), buzzer, got.buzzer);
        if (busy === 1'b1) busyCount++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        flap  = 1'b0;
        score = 1'b0;
        crash = 1'b0;
        mute  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_led_n", led_n, 1'b1);
        checkOutput("reset_buzzer", buzzer, 1'b0);
        rst_n = 1'b1;

        $display("[TB] single flap");
        busyCount = 0;
        applyStimulus(1, 0, 0, 0);
        idle(40);
        checkCount("flap_len", busyCount, 32);

        $display("[TB] flap and crash together");
        busyCount = 0;
        applyStimulus(1, 0, 1, 0);
        idle(70);
        checkCount("flap_crash_len", busyCount, 64);

        $display("[TB] crash then lower-priority score");
        busyCount = 0;
        applyStimulus(0, 0, 1, 0);
        idle(9);
        applyStimulus(0, 1, 0, 0);
        idle(70);
        checkCount("crash_score_len", busyCount, 64);

        $display("[TB] score then higher-priority crash");
        busyCount = 0;
        applyStimulus(0, 1, 0, 0);
        idle(9);
        applyStimulus(0, 0, 1, 0);
        idle(70);
        checkCount("score_crash_len", busyCount, 74);

        $display("[TB] flap retrigger");
        busyCount = 0;
        applyStimulus(1, 0, 0, 0);
        idle(19);
        applyStimulus(1, 0, 0, 0);
        idle(40);
        checkCount("flap_retrig_len", busyCount, 52);

        $display("[TB] flap in final cycle");
        busyCount = 0;
        applyStimulus(1, 0, 0, 0);
        idle(31);
        applyStimulus(1, 0, 0, 0);
        idle(40);
        checkCount("flap_last_len", busyCount, 64);

        $display("[TB] mute mid-sound");
        busyCount = 0;
        applyStimulus(1, 0, 0, 0);
        idle(4);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1);
        idle(30);
        checkCount("mute_len", busyCount, 32);

        $display("[TB] held flap pulse");
        busyCount = 0;
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
        idle(40);
        checkCount("held_len", busyCount, 34);

        $display("[TB] single score");
        busyCount = 0;
        applyStimulus(0, 1, 0, 0);
        idle(20);
        checkCount("score_len", busyCount, 16);

        $display("[TB] reset mid-crash");
        applyStimulus(0, 0, 1, 0);
        idle(14);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_busy", busy, 1'b0);
        checkOutput("async_led_n", led_n, 1'b1);
        checkOutput("async_buzzer", buzzer, 1'b0);
        mActive = 1'b0;
        mId     = 0;
        mAge    = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        busyCount = 0;
        applyStimulus(1, 0, 0, 0);
        idle(40);
        checkCount("post_reset_len", busyCount, 32);

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule

// File: doc/sfx_beeper.md
SFX_BEEPER -- requirements
Module: sfx_beeper

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: system clock frequency; documentation only, no logic depends on it.
REQ-002 Parameter FLAP_HALF, default 25_000: flap-tone half-period in clocks (1 kHz).
REQ-003 Parameter FLAP_LEN, default 5_000_000: flap-tone duration in clocks (100 ms).
REQ-004 Parameter SCORE_HALF, default 12_500: score-tone half-period in clocks (2 kHz).
REQ-005 Parameter SCORE_LEN, default 2_500_000: score-tone duration in clocks (50 ms).
REQ-006 Parameter CRASH_HALF, default 50_000: crash-tone half-period in clocks (500 Hz).
REQ-007 Parameter CRASH_LEN, default 25_000_000: crash-tone duration in clocks (500 ms).
REQ-008 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-009 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-010 Port flap_pulse  input  1  one-cycle active-high event from the debounced key path.
REQ-011 Port score_pulse  input  1  one-cycle active-high score event.
REQ-012 Port crash_pulse  input  1  one-cycle active-high collision event.
REQ-013 Port mute  input  1  level; 1 forces buzzer low without affecting timing.
REQ-014 Port buzzer  output  1  square-wave drive, registered.
REQ-015 Port led_n  output  1  active-low indicator, 0 while a sound plays, registered.
REQ-016 Port busy  output  1  1 while a sound plays, registered.

Function
REQ-017 Two-state FSM: IDLE, PLAY; current sound id is one of NONE, FLAP, SCORE, CRASH.
REQ-018 Priority: CRASH > SCORE > FLAP; if pulses coincide in one cycle, only the highest is accepted.
REQ-019 Accept rule: a pulse is accepted in IDLE, or in PLAY when its priority >= the current sound's priority; a lower-priority pulse is dropped.
REQ-020 Accepting in cycle N: from cycle N+1, busy=1, led_n=0, buzzer=~mute, half counter=0, duration counter=0, id=accepted sound; this restarts a sound already playing (retrigger).
REQ-021 Half counter increments each PLAY cycle; at HALF-1 it wraps to 0 and the internal tone bit toggles, giving a period of exactly 2*HALF clocks.
REQ-022 buzzer = tone bit AND NOT mute, registered; in IDLE, buzzer=0.
REQ-023 busy remains 1 for exactly LEN cycles after acceptance (absent retrigger), then the FSM returns to IDLE with busy=0, led_n=1, buzzer=0, id=NONE.
REQ-024 A pulse accepted in the last PLAY cycle takes precedence over expiry; the FSM stays in PLAY with a restarted sound.
REQ-025 Counter widths are derived from the largest LEN and HALF (clog2); counters never wrap within a sound.
REQ-026 Changing mute mid-sound takes effect on buzzer in the next cycle; duration and phase are unaffected.
REQ-027 Pulses held high for multiple cycles are treated as repeated events (each cycle retriggers); no edge detection.

Reset
REQ-028 While rst_n=0: FSM=IDLE, id=NONE, both counters=0, tone bit=0, buzzer=0, busy=0, led_n=1.
REQ-029 Asserting reset mid-sound aborts it immediately (asynchronously); after release the block is idle and the first clock can accept a pulse.

Structure
REQ-030 Package sfx_pkg holds the sound-id enum and default HALF/LEN constants; the top selects parameters by id.
REQ-031 One sub-module, tone_gen: half-period divider with restart input, half-length input and tone-bit output.

Verification (bench parameters FLAP_HALF=4/LEN=32, SCORE_HALF=2/LEN=16, CRASH_HALF=8/LEN=64)
REQ-032 flap_pulse at cycle 10 -> busy high cycles 11..42, buzzer toggling every 4 cycles starting high, led_n mirrors busy.
REQ-033 flap and crash pulses in the same cycle -> crash tone (period 16) for 64 cycles, flap ignored.
REQ-034 crash at 10, score at 20 -> score dropped, busy falls after cycle 74; score at 10, crash at 20 -> crash restarts, busy until cycle 84.
REQ-035 flap at 10 and flap at 30 -> retrigger, busy continuous until cycle 62; flap in final cycle 42 -> busy stays high.
REQ-036 mute=1 during cycles 15..20 of a flap sound -> buzzer 0 in cycles 16..21, busy/phase unchanged.
REQ-037 rst_n low at cycle 25 of a crash sound -> busy=0, buzzer=0, led_n=1 immediately; flap pulse after release plays normally.
